// File: rtl/cam_lookup_ctrl.sv
// cam_lookup_ctrl: sequencing controller for an external CAM array.
// Accepts one request at a time, writes, invalidates or searches the array,
// priority-encodes the search result and holds the response until taken.
module cam_lookup_ctrl #(
    parameter  int WORDS = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(WORDS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [1:0]             req_op_i,
    input  logic [AW-1:0]          req_addr_i,
    input  logic [WIDTH-1:0]       req_data_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic                   rsp_hit_o,
    output logic [AW-1:0]          rsp_index_o,
    output logic                   rsp_multi_o,
    output logic [WORDS-1:0]       cell_we_o,
    output logic [WIDTH-1:0]       cell_data_o,
    output logic                   cell_cmp_en_o,
    output logic [WIDTH-1:0]       cell_cmp_o,
    input  logic [WORDS*WIDTH-1:0] cell_match_i
);

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_SEARCH = 2'b01;
    localparam logic [1:0] OP_INVAL  = 2'b10;

    typedef enum logic [2:0] {IDLE, WRITE, SEARCH, ENCODE, RESP} state_t;

    state_t           state;
    state_t           next_state;
    logic             armed;
    logic             accept;
    logic [1:0]       op_q;
    logic [AW-1:0]    addr_q;
    logic [WIDTH-1:0] data_q;
    logic [WORDS-1:0] valid_q;
    logic [WORDS-1:0] word_match_q;
    logic [WORDS-1:0] search_match;
    logic             hit_q;
    logic [AW-1:0]    index_q;
    logic             multi_q;
    logic             enc_hit;
    logic [AW-1:0]    enc_index;
    logic             enc_multi;
    logic [AW:0]      enc_count;

    // State register; armed delays req_ready until the first edge out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= next_state;
            armed <= 1'b1;
        end
    end

    // Next-state decode, handshakes and array drive for the current state
    always_comb begin
        next_state    = state;
        accept        = 1'b0;
        req_ready_o   = 1'b0;
        rsp_valid_o   = 1'b0;
        cell_we_o     = '0;
        cell_data_o   = '0;
        cell_cmp_en_o = 1'b0;
        cell_cmp_o    = '0;
        case (state)
            IDLE: begin
                req_ready_o = armed;
                accept      = armed && req_valid_i;
                if (accept) begin
                    case (req_op_i)
                        OP_WRITE:  next_state = WRITE;
                        OP_INVAL:  next_state = WRITE;
                        OP_SEARCH: next_state = SEARCH;
                        default:   next_state = RESP;
                    endcase
                end
            end
            WRITE: begin
                if (op_q == OP_WRITE) begin
                    cell_we_o[addr_q] = 1'b1;
                    cell_data_o       = data_q;
                end
                next_state = RESP;
            end
            SEARCH: begin
                cell_cmp_en_o = 1'b1;
                cell_cmp_o    = data_q;
                next_state    = ENCODE;
            end
            ENCODE: begin
                next_state = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Capture the accepted request so the array sees stable operands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else if (accept) begin
            op_q   <= req_op_i;
            addr_q <= req_addr_i;
            data_q <= req_data_i;
        end
    end

    // Entry valid bits: set by a write, cleared by an invalidate
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (state == WRITE) begin
            if (op_q == OP_WRITE) begin
                valid_q[addr_q] <= 1'b1;
            end else if (op_q == OP_INVAL) begin
                valid_q[addr_q] <= 1'b0;
            end
        end
    end

    // Reduce per-bit match lines to per-entry matches, masked by validity
    always_comb begin
        search_match = '0;
        for (int w = 0; w < WORDS; w++) begin
            search_match[w] = (&cell_match_i[w*WIDTH +: WIDTH]) & valid_q[w];
        end
    end

    // Word matches are sampled only at the end of the compare cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_match_q <= '0;
        end else if (state == SEARCH) begin
            word_match_q <= search_match;
        end
    end

    // Priority encoder: lowest matching index wins, count flags multiple hits
    always_comb begin
        enc_hit   = 1'b0;
        enc_index = '0;
        enc_count = '0;
        for (int w = WORDS - 1; w >= 0; w--) begin
            if (word_match_q[w]) begin
                enc_hit   = 1'b1;
                enc_index = w[AW-1:0];
            end
            enc_count = enc_count + {{AW{1'b0}}, word_match_q[w]};
        end
        enc_multi = (enc_count > {{AW{1'b0}}, 1'b1});
    end

    // Response registers: cleared per request, loaded from the encoder
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q   <= 1'b0;
            index_q <= '0;
            multi_q <= 1'b0;
        end else if (accept) begin
            hit_q   <= 1'b0;
            index_q <= '0;
            multi_q <= 1'b0;
        end else if (state == ENCODE) begin
            hit_q   <= enc_hit;
            index_q <= enc_index;
            multi_q <= enc_multi;
        end
    end

    assign rsp_hit_o   = hit_q;
    assign rsp_index_o = index_q;
    assign rsp_multi_o = multi_q;

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// tb_cam_lookup_ctrl: directed bench for cam_lookup_ctrl with a behavioural
// CAM array and a scoreboard of expected responses.
module tb_cam_lookup_ctrl;

    localparam int WORDS = 8;
    localparam int WIDTH = 8;
    localparam int AW    = 3;

    typedef struct {
        logic          hit;
        logic [AW-1:0] index;
        logic          multi;
        int            latency;
    } exp_t;

    logic                   clk;
    logic                   reset;
    logic                   req_valid_i;
    logic                   req_ready_o;
    logic [1:0]             req_op_i;
    logic [AW-1:0]          req_addr_i;
    logic [WIDTH-1:0]       req_data_i;
    logic                   rsp_valid_o;
    logic                   rsp_ready_i;
    logic                   rsp_hit_o;
    logic [AW-1:0]          rsp_index_o;
    logic                   rsp_multi_o;
    logic [WORDS-1:0]       cell_we_o;
    logic [WIDTH-1:0]       cell_data_o;
    logic                   cell_cmp_en_o;
    logic [WIDTH-1:0]       cell_cmp_o;
    logic [WORDS*WIDTH-1:0] cell_match_i;

    logic [WIDTH-1:0] mem [WORDS];
    logic [WORDS-1:0] force_ones;
    exp_t             sb [$];
    int               checks;
    int               errors;

    cam_lookup_ctrl #(.WORDS(WORDS), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_addr_i   (req_addr_i),
        .req_data_i   (req_data_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_hit_o    (rsp_hit_o),
        .rsp_index_o  (rsp_index_o),
        .rsp_multi_o  (rsp_multi_o),
        .cell_we_o    (cell_we_o),
        .cell_data_o  (cell_data_o),
        .cell_cmp_en_o(cell_cmp_en_o),
        .cell_cmp_o   (cell_cmp_o),
        .cell_match_i (cell_match_i)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Array storage model: cells latch broadcast data on their write enable
    always @(posedge clk) begin
        for (int w = 0; w < WORDS; w++) begin
            if (cell_we_o[w]) begin
                mem[w] <= cell_data_o;
            end
        end
    end

    // Array match-line model, with a per-entry override to force all-ones
    always_comb begin
        cell_match_i = '0;
        for (int w = 0; w < WORDS; w++) begin
            for (int b = 0; b < WIDTH; b++) begin
                cell_match_i[w*WIDTH+b] = force_ones[w] | ~(mem[w][b] ^ cell_cmp_o[b]);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
        check({tag, "_cell_we"}, 32'(cell_we_o), 32'd0);
        check({tag, "_cell_data"}, 32'(cell_data_o), 32'd0);
        check({tag, "_cell_cmp_en"}, 32'(cell_cmp_en_o), 32'd0);
        check({tag, "_cell_cmp"}, 32'(cell_cmp_o), 32'd0);
    endtask

    // Issue one request, observe array activity, then check the response
    task automatic apply_stimulus(input string tag, input logic [1:0] op,
                                  input logic [AW-1:0] addr, input logic [WIDTH-1:0] data,
                                  input logic e_hit, input logic [AW-1:0] e_idx,
                                  input logic e_multi, input int hold);
        exp_t e;
        int   cycles;
        int   waited;
        e.hit     = e_hit;
        e.index   = e_idx;
        e.multi   = e_multi;
        e.latency = (op == 2'b01) ? 3 : ((op == 2'b11) ? 1 : 2);
        sb.push_back(e);
        waited = 0;
        while (!req_ready_o && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready_o) begin
            check({tag, "_ready_timeout"}, 32'd0, 32'd1);
        end
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_addr_i  = addr;
        req_data_i  = data;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        req_op_i    = 2'b00;
        req_addr_i  = '0;
        req_data_i  = '0;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                if (op == 2'b00) begin
                    check({tag, "_we"}, 32'(cell_we_o), 32'(1) << addr);
                    check({tag, "_wdata"}, 32'(cell_data_o), 32'(data));
                end else if (op == 2'b01) begin
                    check({tag, "_cmp_en"}, 32'(cell_cmp_en_o), 32'd1);
                    check({tag, "_cmp_key"}, 32'(cell_cmp_o), 32'(data));
                end else begin
                    check({tag, "_no_we"}, 32'(cell_we_o), 32'd0);
                    check({tag, "_no_cmp"}, 32'(cell_cmp_en_o), 32'd0);
                end
            end
            if (cycles == 2 && op == 2'b00) begin
                check({tag, "_we_pulse"}, 32'(cell_we_o), 32'd0);
            end
        end while (!rsp_valid_o && cycles < 10);
        check_output(tag, cycles, hold);
    endtask

    // Pop the expected response and compare it, holding rsp_ready low for a while
    task automatic check_output(input string tag, input int cycles, input int hold);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, 32'(cycles), 32'(e.latency));
        check({tag, "_hit"}, 32'(rsp_hit_o), 32'(e.hit));
        check({tag, "_index"}, 32'(rsp_index_o), 32'(e.index));
        check({tag, "_multi"}, 32'(rsp_multi_o), 32'(e.multi));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(rsp_valid_o), 32'd1);
            check({tag, "_hold_ready"}, 32'(req_ready_o), 32'd0);
            check({tag, "_hold_hit"}, 32'(rsp_hit_o), 32'(e.hit));
            check({tag, "_hold_index"}, 32'(rsp_index_o), 32'(e.index));
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        check({tag, "_rsp_drop"}, 32'(rsp_valid_o), 32'd0);
        check({tag, "_back_idle"}, 32'(req_ready_o), 32'd1);
    endtask

    // Directed sequence
    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b0;
        req_valid_i = 1'b0;
        req_op_i    = 2'b00;
        req_addr_i  = '0;
        req_data_i  = '0;
        rsp_ready_i = 1'b0;
        force_ones  = '0;
        for (int w = 0; w < WORDS; w++) begin
            mem[w] = '0;
        end

        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready_o), 32'd0);
        check_idle_outputs("rst");
        reset = 1'b1;
        #1;
        check("rst_release_ready", 32'(req_ready_o), 32'd0);
        @(negedge clk);
        check("first_edge_ready", 32'(req_ready_o), 32'd1);

        $display("[TB] write and search single entry");
        apply_stimulus("wr3", 2'b00, 3'd3, 8'hA5, 1'b0, 3'd0, 1'b0, 0);
        check_idle_outputs("after_wr");
        apply_stimulus("srA5", 2'b01, 3'd0, 8'hA5, 1'b1, 3'd3, 1'b0, 0);

        $display("[TB] multiple match with held response");
        apply_stimulus("wr2", 2'b00, 3'd2, 8'h3C, 1'b0, 3'd0, 1'b0, 0);
        apply_stimulus("wr5", 2'b00, 3'd5, 8'h3C, 1'b0, 3'd0, 1'b0, 0);
        apply_stimulus("sr3C", 2'b01, 3'd0, 8'h3C, 1'b1, 3'd2, 1'b1, 5);

        $display("[TB] reserved op and overwrite");
        apply_stimulus("rsvd", 2'b11, 3'd4, 8'h3C, 1'b0, 3'd0, 1'b0, 0);
        apply_stimulus("ovr5", 2'b00, 3'd5, 8'h77, 1'b0, 3'd0, 1'b0, 0);
        apply_stimulus("sr3C_b", 2'b01, 3'd0, 8'h3C, 1'b1, 3'd2, 1'b0, 0);
        apply_stimulus("sr77", 2'b01, 3'd0, 8'h77, 1'b1, 3'd5, 1'b0, 0);
        apply_stimulus("sr_miss", 2'b01, 3'd0, 8'h11, 1'b0, 3'd0, 1'b0, 0);

        $display("[TB] invalidate with forced match lines");
        apply_stimulus("inv3", 2'b10, 3'd3, 8'hFF, 1'b0, 3'd0, 1'b0, 0);
        force_ones[3] = 1'b1;
        apply_stimulus("srA5_inv", 2'b01, 3'd0, 8'hA5, 1'b0, 3'd0, 1'b0, 0);
        apply_stimulus("inv3_again", 2'b10, 3'd3, 8'h00, 1'b0, 3'd0, 1'b0, 0);
        apply_stimulus("srA5_inv2", 2'b01, 3'd0, 8'hA5, 1'b0, 3'd0, 1'b0, 0);
        force_ones = '0;

        $display("[TB] reset during search");
        req_valid_i = 1'b1;
        req_op_i    = 2'b01;
        req_data_i  = 8'h3C;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        req_data_i  = '0;
        check("pre_rst_cmp_en", 32'(cell_cmp_en_o), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_ready", 32'(req_ready_o), 32'd0);
        check_idle_outputs("mid_rst");
        repeat (2) @(negedge clk);
        check("rst_hold_valid", 32'(rsp_valid_o), 32'd0);
        reset = 1'b1;
        #1;
        check("rst2_release_ready", 32'(req_ready_o), 32'd0);
        @(negedge clk);
        check("rst2_first_edge_ready", 32'(req_ready_o), 32'd1);
        check("rst2_no_rsp", 32'(rsp_valid_o), 32'd0);
        apply_stimulus("sr3C_cleared", 2'b01, 3'd0, 8'h3C, 1'b0, 3'd0, 1'b0, 0);
        force_ones = '1;
        apply_stimulus("sr_all_invalid", 2'b01, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 0);
        force_ones = '0;

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
